// File: rtl/rx_fifo_if.sv
// Handshake bundle between the UART receiver/core side and rx_fifo.
// master drives the push/pop requests; slave (the FIFO) returns status and head data.
interface rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic              ovf_clr;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output rx_valid, rx_data, rd_en, ovf_clr,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  rx_valid, rx_data, rd_en, ovf_clr,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/rx_fifo.sv
// Receive byte FIFO, first-word-fall-through, with sticky overflow on dropped bytes.
// Define RX_FIFO_BYPASS_EN to let an empty FIFO forward (and consume) rx_data directly.
module rx_fifo #(
  parameter int ADDR_W = 4
) (
  input logic      clk,
  input logic      rstn,
  rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_cnt;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_bypass;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == C_DEPTH);
  assign w_pop   = bus.rd_en & ~w_empty;

`ifdef RX_FIFO_BYPASS_EN
  // Empty + incoming byte + pop: hand the byte straight through, never store it.
  assign w_bypass = bus.rx_valid & w_empty & bus.rd_en;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = bus.rx_valid & (~w_full | w_pop) & ~w_bypass;
  assign w_drop = bus.rx_valid & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_overflow <= w_drop | (r_overflow & ~bus.ovf_clr);
    end
  end

`ifdef RX_FIFO_BYPASS_EN
  assign bus.rd_data = w_empty ? (bus.rx_valid ? bus.rx_data : 8'h00) : r_mem[r_rp];
`else
  assign bus.rd_data = w_empty ? 8'h00 : r_mem[r_rp];
`endif

  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_cnt;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo at depth 4: table of single-cycle vectors plus
// hand sequences for async reset, pointer wrap and the empty-FIFO read/write case.
module tb_rx_fifo;
  localparam int AW = 2;

  logic clk;
  logic rstn;

  rx_fifo_if #(.ADDR_W(AW)) bus ();

  rx_fifo #(.ADDR_W(AW)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rd, input logic clr);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rd_en    = rd;
    bus.ovf_clr  = clr;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_data,
                           input logic [2:0] e_cnt, input logic e_ovf);
    chk({tag, ".rd_data"},  bus.rd_data, e_data);
    chk({tag, ".count"},    {5'd0, bus.count}, {5'd0, e_cnt});
    chk({tag, ".empty"},    {7'd0, bus.empty}, {7'd0, (e_cnt == 3'd0)});
    chk({tag, ".full"},     {7'd0, bus.full},  {7'd0, (e_cnt == 3'd4)});
    chk({tag, ".overflow"}, {7'd0, bus.overflow}, {7'd0, e_ovf});
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rd, input logic clr,
                     input logic [7:0] e_data, input logic [2:0] e_cnt, input logic e_ovf);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd; t.clr = clr;
    t.e_data = e_data; t.e_cnt = e_cnt; t.e_ovf = e_ovf;
    tbl.push_back(t);
  endtask

  initial begin
    idle();
    rstn = 1'b0;

    //   v  data   rd clr   exp_data cnt ovf  (state after the edge, inputs idle)
    add(1, 8'hA1, 0, 0,   8'hA1, 1, 0);
    add(1, 8'hB2, 0, 0,   8'hA1, 2, 0);
    add(1, 8'hC3, 0, 0,   8'hA1, 3, 0);
    add(0, 8'h00, 1, 0,   8'hB2, 2, 0);
    add(0, 8'h00, 1, 0,   8'hC3, 1, 0);
    add(0, 8'h00, 1, 0,   8'h00, 0, 0);
    add(0, 8'h00, 1, 0,   8'h00, 0, 0);
    add(1, 8'h10, 0, 0,   8'h10, 1, 0);
    add(1, 8'h11, 0, 0,   8'h10, 2, 0);
    add(1, 8'h12, 0, 0,   8'h10, 3, 0);
    add(1, 8'h13, 0, 0,   8'h10, 4, 0);
    add(1, 8'h14, 0, 0,   8'h10, 4, 1);
    add(0, 8'h00, 1, 0,   8'h11, 3, 1);
    add(0, 8'h00, 1, 0,   8'h12, 2, 1);
    add(0, 8'h00, 1, 0,   8'h13, 1, 1);
    add(0, 8'h00, 1, 0,   8'h00, 0, 1);
    add(0, 8'h00, 0, 1,   8'h00, 0, 0);
    add(1, 8'h20, 0, 0,   8'h20, 1, 0);
    add(1, 8'h21, 0, 0,   8'h20, 2, 0);
    add(1, 8'h22, 0, 0,   8'h20, 3, 0);
    add(1, 8'h23, 0, 0,   8'h20, 4, 0);
    add(1, 8'h55, 1, 0,   8'h21, 4, 0);
    add(1, 8'h66, 0, 1,   8'h21, 4, 1);
    add(0, 8'h00, 0, 1,   8'h21, 4, 0);
    add(0, 8'h00, 1, 0,   8'h22, 3, 0);
    add(0, 8'h00, 1, 0,   8'h23, 2, 0);
    add(0, 8'h00, 1, 0,   8'h55, 1, 0);
    add(0, 8'h00, 1, 0,   8'h00, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 8'h00, 3'd0, 1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_state("idle", 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].clr);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk_state($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_ovf);
    end

    // pointer wrap: ten push/pop rounds through a 4-deep array
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk($sformatf("wrap%0d.rd_data", k), bus.rd_data, 8'(k));
      chk($sformatf("wrap%0d.count", k), {5'd0, bus.count}, 8'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk($sformatf("wrap%0d.empty", k), {7'd0, bus.empty}, 8'd1);
    end

    // empty FIFO, byte arriving together with a pop request
    drive(1'b1, 8'h7E, 1'b1, 1'b0);
    #1;
`ifdef RX_FIFO_BYPASS_EN
    chk("bypass.rd_data_same", bus.rd_data, 8'h7E);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk_state("bypass.after", 8'h00, 3'd0, 1'b0);
`else
    chk("nobypass.rd_data_same", bus.rd_data, 8'h00);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk_state("nobypass.after", 8'h7E, 3'd1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    idle();
`endif

    // asynchronous reset with three bytes buffered, away from any clock edge
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hE0 + 8'(k), 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    idle();
    #1;
    chk_state("prereset", 8'hE0, 3'd3, 1'b0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_state("async_reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_reset", 8'h00, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side byte buffer between the UART receiver and the core's input instruction path: the complement of the transmit buffer. Bytes arriving from the UART receiver are pushed in order. The core pops them one at a time through a first-word-fall-through read port. The block tracks occupancy, reports empty/full, and latches a sticky overflow flag when a byte is dropped.

## Interface
Parameters:
- ADDR_W, 4, log2 of depth; depth = 2^ADDR_W bytes (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  single-cycle strobe from the UART receiver; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- rd_en  in  1  pop request from the core.
- rd_data  out  8  head byte (FWFT); 8'h00 whenever empty=1 (bypass case excepted, see Configuration).
- empty  out  1  count==0.
- full  out  1  count==2^ADDR_W.
- count  out  ADDR_W+1  current occupancy.
- overflow  out  1  sticky; a byte was dropped.
- ovf_clr  in  1  clears overflow.

## Operation
- Storage: 2^ADDR_W x 8 array; write pointer wp, read pointer rp, each ADDR_W bits, wrapping modulo 2^ADDR_W; counter cnt, ADDR_W+1 bits.
- pop = rd_en & ~empty. rd_en while empty is ignored: no pointer change, no error flag.
- push = rx_valid & (~full | pop). A push while full is accepted only if a pop occurs in the same cycle.
- On push: mem[wp] <= rx_data, wp <= wp+1. On pop: rp <= rp+1.
- cnt next value:
  - +1 for push only.
  - -1 for pop only.
  - unchanged for both or neither.
- drop = rx_valid & full & ~pop. On drop: the byte is discarded and overflow <= 1.
- overflow next value = drop | (overflow & ~ovf_clr). If drop and ovf_clr occur in the same cycle, set wins.
- rd_data = empty ? 8'h00 : mem[rp]. This is a combinational read of the registered array.
- empty, full and count are decoded from registered cnt only; they have no combinational dependence on the current cycle's inputs.

## Timing
- Reset (rstn=0, asynchronous): wp=rp=0, cnt=0, overflow=0. Outputs: empty=1, full=0, count=0, rd_data=8'h00, overflow=0. Array contents are not reset.
- Reset mid-operation discards all buffered bytes. Any push or pop in progress at the reset edge is lost.
- Write-to-read latency: a byte pushed at edge N is visible on rd_data, with empty=0, after edge N (cycle N+1).
- Pop latency: rd_en high in cycle N advances rd_data to the next byte after edge N.
- Throughput: one push and one pop per cycle sustained.
- Full boundary: at cnt=2^ADDR_W, full=1. Simultaneous rx_valid and rd_en keep cnt at 2^ADDR_W, and no drop occurs.
- Pointer wrap: the pointer at 2^ADDR_W-1 returns to 0 with no gap or duplicate.

## Configuration
- RX_FIFO_BYPASS_EN defined: when empty=1 and rx_valid=1, rd_data shows rx_data combinationally.
  - If rd_en=1 in that cycle, the byte is consumed directly: no write, pointers and cnt unchanged, empty stays 1.
  - If rd_en=0, the byte is pushed normally.
- RX_FIFO_BYPASS_EN undefined: an empty FIFO always returns 8'h00 and ignores rd_en. An incoming byte is readable only from the following cycle.

## Test plan
ADDR_W=2 (depth 4) unless stated otherwise.
- Reset then idle: empty=1, full=0, count=0, rd_data=8'h00, overflow=0. Assert rstn low mid-stream with count=3 -> count=0 immediately, without waiting for a clock edge.
- Push 8'hA1, 8'hB2, 8'hC3 on consecutive cycles, then pop three times -> rd_data sequence A1, B2, C3; count steps 1,2,3,2,1,0; empty returns to 1.
- Push 4 bytes 8'h10..8'h13 -> full=1, count=4. Fifth push of 8'h14 -> dropped and overflow=1. Popping returns 10..13 only. ovf_clr pulse -> overflow=0.
- While full, assert rx_valid=8'h55 together with rd_en -> count stays 4, no overflow, 8'h55 emerges after the three remaining older bytes.
- Wrap: 10 rounds of push-then-pop of 8'h00..8'h09 -> each byte read back matches; pointers wrap twice with no corruption.
- Empty with rx_valid=8'h7E and rd_en in the same cycle:
  - with RX_FIFO_BYPASS_EN -> rd_data=8'h7E that cycle; count stays 0 after the edge.
  - without it -> rd_data=8'h00 that cycle; after the edge count=1 and rd_data=8'h7E.
